// File: rtl/ethstream_tx_arbiter.sv
// rtl/ethstream_tx_arbiter.sv - round-robin packet arbiter feeding the UDP streamer TX input
//
// Purpose: shares one AXI4-Stream byte sink among NUM_SRC framed packet sources.
//   A grant is held from the first beat through tlast, so packets are never interleaved.
//   Arbitration takes one IDLE cycle, which leaves a one-cycle bubble between packets.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   i_link_up      streamer link established; only gates new grants
//   i_s_tdata      source data, source i at [i*DATA_W +: DATA_W]
//   i_s_tvalid     per-source valid
//   i_s_tlast      per-source last
//   o_s_tready     per-source ready (only the granted source can be ready)
//   o_m_tdata      arbitrated data to streamer
//   o_m_tvalid     arbitrated valid
//   o_m_tlast      arbitrated last
//   i_m_tready     streamer ready
//   o_grant_valid  a packet is in progress
//   o_grant_idx    index of the granted source
//   o_pkt_count    completed packets per source, source i at [i*CNT_W +: CNT_W]
module ethstream_tx_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_link_up,
  input  logic [NUM_SRC*DATA_W-1:0]  i_s_tdata,
  input  logic [NUM_SRC-1:0]         i_s_tvalid,
  input  logic [NUM_SRC-1:0]         i_s_tlast,
  output logic [NUM_SRC-1:0]         o_s_tready,
  output logic [DATA_W-1:0]          o_m_tdata,
  output logic                       o_m_tvalid,
  output logic                       o_m_tlast,
  input  logic                       i_m_tready,
  output logic                       o_grant_valid,
  output logic [IDX_W-1:0]           o_grant_idx,
  output logic [NUM_SRC*CNT_W-1:0]   o_pkt_count
);

  typedef enum logic {
    ST_IDLE,
    ST_PASS
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [IDX_W-1:0]         r_grant_idx;
  logic [IDX_W-1:0]         r_last_grant;
  logic [IDX_W-1:0]         w_next_idx;
  logic                     w_any_req;
  logic                     w_xfer_last;
  logic [NUM_SRC*CNT_W-1:0] r_pkt_count;

  // Round-robin search starting at last_grant+1 with wrap. The loop runs from
  // the farthest candidate down to the nearest, so the nearest requester wins.
  always_comb begin
    w_next_idx = r_last_grant;
    w_any_req  = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (i_s_tvalid[(int'(r_last_grant) + k) % NUM_SRC]) begin
        w_next_idx = IDX_W'((int'(r_last_grant) + k) % NUM_SRC);
        w_any_req  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath is a pure mux in PASS; the sink sees nothing at all in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    o_m_tdata   = '0;
    o_m_tvalid  = 1'b0;
    o_m_tlast   = 1'b0;
    o_s_tready  = '0;
    w_xfer_last = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_link_up && w_any_req) begin
          w_state_nxt = ST_PASS;
        end
      end
      ST_PASS: begin
        o_m_tdata               = i_s_tdata[r_grant_idx*DATA_W +: DATA_W];
        o_m_tvalid              = i_s_tvalid[r_grant_idx];
        o_m_tlast               = i_s_tlast[r_grant_idx];
        o_s_tready[r_grant_idx] = i_m_tready;
        w_xfer_last = i_s_tvalid[r_grant_idx] & i_m_tready & i_s_tlast[r_grant_idx];
        if (w_xfer_last) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pointer resets to the top index so the first search begins at source 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_idx  <= '0;
      r_last_grant <= IDX_W'(NUM_SRC - 1);
      r_pkt_count  <= '0;
    end else begin
      if (r_state == ST_IDLE && w_state_nxt == ST_PASS) begin
        r_grant_idx <= w_next_idx;
      end
      if (w_xfer_last) begin
        r_last_grant <= r_grant_idx;
        r_pkt_count[r_grant_idx*CNT_W +: CNT_W] <=
          r_pkt_count[r_grant_idx*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

  assign o_grant_valid = (r_state == ST_PASS);
  assign o_grant_idx   = r_grant_idx;
  assign o_pkt_count   = r_pkt_count;

endmodule
